// File: rtl/final385_soc_keycode_in.sv
// Avalon-MM keycode input port: fabric pushes 8-bit keycodes into a FIFO that the CPU drains via DATA.
// Optional interrupt mask register and irq output are built when KEYCODE_IN_IRQ_EN is defined.
module final385_soc_keycode_in #(
  parameter int DEPTH = 8,
  parameter int CW    = 5
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        chipselect,
  input  logic [1:0]  address,
  input  logic        read,
  input  logic        write_n,
  input  logic [31:0] writedata,
  output logic [31:0] readdata,
  input  logic [7:0]  in_port,
  input  logic        in_valid,
  output logic        irq
);

  localparam int AW = $clog2(DEPTH);

  logic [7:0]    mem [DEPTH];
  logic [AW-1:0] rd_ptr;
  logic [AW-1:0] wr_ptr;
  logic [CW-1:0] count;
  logic          overflow;

  logic empty, full;
  logic bus_rd, bus_wr;
  logic pop, push_ok, flush, ovf_set, ovf_clr;
  logic unused_wdata;

  assign empty   = (count == '0);
  assign full    = (count == CW'(DEPTH));
  assign bus_rd  = chipselect && read;
  assign bus_wr  = chipselect && !write_n;
  assign pop     = bus_rd && (address == 2'd0) && !empty;
  // A full FIFO still accepts a push when a pop frees a slot in the same cycle.
  assign push_ok = in_valid && (!full || pop);
  assign ovf_set = in_valid && full && !pop;
  assign ovf_clr = bus_wr && (address == 2'd1) && writedata[10];
  assign flush   = bus_wr && (address == 2'd3) && writedata[0];

  assign unused_wdata = ^writedata;

  always_ff @(posedge clk) begin
    if (reset) begin
      rd_ptr   <= '0;
      wr_ptr   <= '0;
      count    <= '0;
      overflow <= 1'b0;
    end else begin
      if (flush) begin
        rd_ptr <= '0;
        wr_ptr <= '0;
        count  <= '0;
      end else begin
        if (push_ok) wr_ptr <= wr_ptr + AW'(1);
        if (pop)     rd_ptr <= rd_ptr + AW'(1);
        if (push_ok && !pop)      count <= count + CW'(1);
        else if (pop && !push_ok) count <= count - CW'(1);
      end
      // Set has priority over a same-cycle clear so no overflow event is lost.
      if (ovf_set)      overflow <= 1'b1;
      else if (ovf_clr) overflow <= 1'b0;
    end
  end

  // Storage is never reset; pointers define which entries are live.
  always_ff @(posedge clk) begin
    if (push_ok && !flush && !reset) mem[wr_ptr] <= in_port;
  end

`ifdef KEYCODE_IN_IRQ_EN
  logic [1:0] mask;

  always_ff @(posedge clk) begin
    if (reset) mask <= 2'b00;
    else if (bus_wr && (address == 2'd2)) mask <= writedata[1:0];
  end

  assign irq = (mask[0] & !empty) | (mask[1] & overflow);
`else
  logic [1:0] mask;

  assign mask = 2'b00;
  assign irq  = 1'b0;
`endif

  always_comb begin
    readdata = '0;
    case (address)
      2'd0: begin
        readdata[8]   = !empty;
        readdata[7:0] = empty ? 8'h00 : mem[rd_ptr];
      end
      2'd1: begin
        readdata[CW-1:0] = count;
        readdata[8]      = empty;
        readdata[9]      = full;
        readdata[10]     = overflow;
      end
      2'd2:    readdata[1:0] = mask;
      default: readdata = '0;
    endcase
  end

endmodule
